// File: rtl/turbo_check_pkg.sv
`default_nettype none
// ============================================================================
// Module   : turbo_check_pkg
// Brief    : Shared types and helpers for the turbo frame error counter.
// Revision : 1.0 - initial release
// ============================================================================
package turbo_check_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chk_state_t;

    // Saturating add of two counters of the given width (1..64), passed
    // zero-extended to 64 bits; the result never wraps past 2^width-1.
    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int          width
    );
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << width) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ref_frame_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : ref_frame_pingpong
// Brief    : Two-slot reference frame store with write/read pointers.
// Revision : 1.0 - initial release
// ============================================================================
module ref_frame_pingpong #(
    parameter int N        = 8,
    localparam int IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                load,
    input  logic                ref_x [N],
    input  logic                rel,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                ref_ready,
    output logic                ref_avail,
    output logic                rd_bit
);

    typedef logic [N-1:0] ref_frame_t;

    ref_frame_t  r_slot [2];
    logic        r_wr_sel;
    logic        r_rd_sel;
    logic [1:0]  r_occ;
    ref_frame_t  w_ref_packed;
    logic        w_load;

    always_comb begin
        w_ref_packed = '0;
        for (int i = 0; i < N; i++) begin
            w_ref_packed[i] = ref_x[i];
        end
    end

    assign ref_ready = (r_occ != 2'd2);
    assign ref_avail = (r_occ != 2'd0);
    assign w_load    = load && ref_ready;
    assign rd_bit    = r_slot[r_rd_sel][rd_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot[0] <= '0;
            r_slot[1] <= '0;
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_occ     <= 2'd0;
        end else if (clear) begin
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_occ     <= 2'd0;
        end else begin
            if (w_load) begin
                r_slot[r_wr_sel] <= w_ref_packed;
                r_wr_sel         <= ~r_wr_sel;
            end
            if (rel) begin
                r_rd_sel <= ~r_rd_sel;
            end
            // Load and release in the same cycle leave occupancy unchanged.
            r_occ <= r_occ + 2'(w_load) - 2'(rel);
        end
    end

endmodule
`default_nettype wire

// File: rtl/turbo_frame_error_counter.sv
`default_nettype none
// ============================================================================
// Module   : turbo_frame_error_counter
// Brief    : Bit-by-bit compare of decoded frames against queued references,
//            with per-frame error count and saturating BER/FER totals.
// Revision : 1.0 - initial release
// ============================================================================
module turbo_frame_error_counter
    import turbo_check_pkg::*;
#(
    parameter int  N        = 8,
    parameter int  CNT_BITS = 32,
    localparam int ERR_BITS = $clog2(N + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                ref_valid,
    input  logic                ref_x [N],
    output logic                ref_ready,
    input  logic                in_valid,
    input  logic                single_x,
    output logic                frame_done,
    output logic [ERR_BITS-1:0] frame_errors,
    output logic                frame_error,
    output logic [CNT_BITS-1:0] total_frames,
    output logic [CNT_BITS-1:0] total_bit_errors,
    output logic [CNT_BITS-1:0] total_frame_errors,
    output logic                ref_overrun,
    output logic                no_ref_err
);

    localparam int IDX_BITS = (N > 1) ? $clog2(N) : 1;

    chk_state_t          r_state;
    chk_state_t          w_state_next;
    logic [IDX_BITS-1:0] r_idx;
    logic [ERR_BITS-1:0] r_err_acc;
    logic [ERR_BITS-1:0] w_err_final;
    logic                r_frame_done;
    logic [ERR_BITS-1:0] r_frame_errors;
    logic                r_frame_error;
    logic [CNT_BITS-1:0] r_total_frames;
    logic [CNT_BITS-1:0] r_total_bit_errors;
    logic [CNT_BITS-1:0] r_total_frame_errors;
    logic                r_ref_overrun;
    logic                r_no_ref_err;

    logic                w_ref_ready;
    logic                w_ref_avail;
    logic                w_ref_bit;
    logic                w_accept;
    logic                w_last;
    logic                w_complete;
    logic                w_bit_err;

    ref_frame_pingpong #(
        .N (N)
    ) u_store (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .load      (ref_valid),
        .ref_x     (ref_x),
        .rel       (w_complete),
        .rd_idx    (r_idx),
        .ref_ready (w_ref_ready),
        .ref_avail (w_ref_avail),
        .rd_bit    (w_ref_bit)
    );

    assign w_accept    = in_valid && w_ref_avail && !clear;
    assign w_last      = (r_idx == IDX_BITS'(N - 1));
    assign w_complete  = w_accept && w_last;
    assign w_bit_err   = single_x ^ w_ref_bit;
    assign w_err_final = r_err_acc + ERR_BITS'(w_bit_err);

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept && !w_last) w_state_next = ST_RUN;
                ST_RUN:  if (w_complete)          w_state_next = ST_IDLE;
                default:                          w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx                <= '0;
            r_err_acc            <= '0;
            r_frame_done         <= 1'b0;
            r_frame_errors       <= '0;
            r_frame_error        <= 1'b0;
            r_total_frames       <= '0;
            r_total_bit_errors   <= '0;
            r_total_frame_errors <= '0;
            r_ref_overrun        <= 1'b0;
            r_no_ref_err         <= 1'b0;
        end else if (clear) begin
            r_idx                <= '0;
            r_err_acc            <= '0;
            r_frame_done         <= 1'b0;
            r_frame_errors       <= '0;
            r_frame_error        <= 1'b0;
            r_total_frames       <= '0;
            r_total_bit_errors   <= '0;
            r_total_frame_errors <= '0;
            r_ref_overrun        <= 1'b0;
            r_no_ref_err         <= 1'b0;
        end else begin
            r_frame_done <= w_complete;
            if (w_accept) begin
                if (w_last) begin
                    r_idx                <= '0;
                    r_err_acc            <= '0;
                    r_frame_errors       <= w_err_final;
                    r_frame_error        <= |w_err_final;
                    r_total_frames       <= CNT_BITS'(sat_add(64'(r_total_frames), 64'd1, CNT_BITS));
                    r_total_bit_errors   <= CNT_BITS'(sat_add(64'(r_total_bit_errors),
                                                              64'(w_err_final), CNT_BITS));
                    r_total_frame_errors <= CNT_BITS'(sat_add(64'(r_total_frame_errors),
                                                              64'(|w_err_final), CNT_BITS));
                end else begin
                    r_idx     <= r_idx + IDX_BITS'(1);
                    r_err_acc <= w_err_final;
                end
            end
            // A full store drops the offered frame; an empty store drops the bit.
            if (ref_valid && !w_ref_ready) begin
                r_ref_overrun <= 1'b1;
            end
            if (in_valid && !w_ref_avail) begin
                r_no_ref_err <= 1'b1;
            end
        end
    end

    assign ref_ready          = w_ref_ready;
    assign frame_done         = r_frame_done;
    assign frame_errors       = r_frame_errors;
    assign frame_error        = r_frame_error;
    assign total_frames       = r_total_frames;
    assign total_bit_errors   = r_total_bit_errors;
    assign total_frame_errors = r_total_frame_errors;
    assign ref_overrun        = r_ref_overrun;
    assign no_ref_err         = r_no_ref_err;

endmodule
`default_nettype wire

// File: tb/tb_turbo_frame_error_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_turbo_frame_error_counter
// Brief    : Directed self-checking bench for turbo_frame_error_counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_turbo_frame_error_counter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        ref_valid;
    logic        ref_x [8];
    logic        ref_ready;
    logic        in_valid;
    logic        single_x;
    logic        frame_done;
    logic [3:0]  frame_errors;
    logic        frame_error;
    logic [31:0] total_frames;
    logic [31:0] total_bit_errors;
    logic [31:0] total_frame_errors;
    logic        ref_overrun;
    logic        no_ref_err;

    int n_cmp  = 0;
    int n_fail = 0;

    turbo_frame_error_counter #(
        .N        (8),
        .CNT_BITS (32)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .clear              (clear),
        .ref_valid          (ref_valid),
        .ref_x              (ref_x),
        .ref_ready          (ref_ready),
        .in_valid           (in_valid),
        .single_x           (single_x),
        .frame_done         (frame_done),
        .frame_errors       (frame_errors),
        .frame_error        (frame_error),
        .total_frames       (total_frames),
        .total_bit_errors   (total_bit_errors),
        .total_frame_errors (total_frame_errors),
        .ref_overrun        (ref_overrun),
        .no_ref_err         (no_ref_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ref(input logic [7:0] f);
        for (int i = 0; i < 8; i++) ref_x[i] = f[i];
    endtask

    task automatic load_ref(input logic [7:0] f);
        set_ref(f);
        ref_valid = 1'b1;
        tick();
        ref_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        single_x = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clear = 1'b0; ref_valid = 1'b0; in_valid = 1'b0; single_x = 1'b0;
        set_ref(8'h00);
        repeat (2) tick();
        n_cmp++; if (ref_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ref_ready); end
        n_cmp++; if ({frame_done, frame_error, ref_overrun, no_ref_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {frame_done, frame_error, ref_overrun, no_ref_err}); end
        n_cmp++; if (frame_errors !== 4'd0) begin n_fail++; $display("FAIL reset_ferrs: got %0d want 0", frame_errors); end
        n_cmp++; if ({total_frames, total_bit_errors, total_frame_errors} !== 96'd0) begin
            n_fail++; $display("FAIL reset_totals: got %0d/%0d/%0d want 0/0/0", total_frames, total_bit_errors, total_frame_errors); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_error_free();
        logic [7:0] f;
        f = 8'hC7;
        load_ref(f);
        for (int i = 0; i < 8; i++) begin
            send_bit(f[i]);
            if (i < 7) begin
                n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL ef_early_done bit%0d: got 1 want 0", i); end
            end
        end
        n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL ef_done: got %b want 1", frame_done); end
        n_cmp++; if ({frame_error, frame_errors} !== 5'd0) begin n_fail++; $display("FAIL ef_errs: got %b/%0d want 0/0", frame_error, frame_errors); end
        n_cmp++; if (total_frames !== 32'd1 || total_bit_errors !== 32'd0 || total_frame_errors !== 32'd0) begin
            n_fail++; $display("FAIL ef_totals: got %0d/%0d/%0d want 1/0/0", total_frames, total_bit_errors, total_frame_errors); end
        tick();
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL ef_pulse: got %b want 0", frame_done); end
    endtask

    task automatic test_errors();
        load_ref(8'hC7);
        send_frame(8'hC7 ^ 8'h21);
        n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL err_done: got %b want 1", frame_done); end
        n_cmp++; if (frame_errors !== 4'd2 || frame_error !== 1'b1) begin
            n_fail++; $display("FAIL err_frame: got %0d/%b want 2/1", frame_errors, frame_error); end
        n_cmp++; if (total_frames !== 32'd2 || total_bit_errors !== 32'd2 || total_frame_errors !== 32'd1) begin
            n_fail++; $display("FAIL err_totals: got %0d/%0d/%0d want 2/2/1", total_frames, total_bit_errors, total_frame_errors); end
        tick();
        n_cmp++; if (frame_errors !== 4'd2 || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL err_hold: got %0d/%b want 2/0", frame_errors, frame_done); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s;
        logic        exp_done;
        load_ref(8'h5A);
        load_ref(8'h3C);
        n_cmp++; if (ref_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got %b want 0", ref_ready); end
        load_ref(8'hFF);
        n_cmp++; if (ref_overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun: got %b want 1", ref_overrun); end
        s = {8'h3C ^ 8'h01, 8'h5A};
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            single_x = s[i];
            tick();
            exp_done = (i == 7) || (i == 15);
            n_cmp++; if (frame_done !== exp_done) begin n_fail++; $display("FAIL b2b_done bit%0d: got %b want %b", i, frame_done, exp_done); end
            if (i == 7) begin
                n_cmp++; if (frame_errors !== 4'd0) begin n_fail++; $display("FAIL b2b_first_errs: got %0d want 0", frame_errors); end
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (frame_errors !== 4'd1 || frame_error !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second_errs: got %0d/%b want 1/1", frame_errors, frame_error); end
        n_cmp++; if (total_frames !== 32'd4 || total_bit_errors !== 32'd3 || total_frame_errors !== 32'd2) begin
            n_fail++; $display("FAIL b2b_totals: got %0d/%0d/%0d want 4/3/2", total_frames, total_bit_errors, total_frame_errors); end
        n_cmp++; if (ref_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after: got %b want 1", ref_ready); end
    endtask

    task automatic test_gaps_no_ref();
        logic [7:0] b;
        int         gap [8];
        // Store is empty here, which also shows the overrun frame was dropped.
        send_bit(1'b1);
        n_cmp++; if (no_ref_err !== 1'b1) begin n_fail++; $display("FAIL noref_flag: got %b want 1", no_ref_err); end
        n_cmp++; if (frame_done !== 1'b0 || total_frames !== 32'd4 || total_bit_errors !== 32'd3) begin
            n_fail++; $display("FAIL noref_counters: got %b/%0d/%0d want 0/4/3", frame_done, total_frames, total_bit_errors); end
        gap = '{1, 0, 0, 2, 1, 0, 3, 0};
        b = 8'hC7 ^ 8'h21;
        load_ref(8'hC7);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i]);
            if (i < 7) begin
                n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL gap_early bit%0d: got 1 want 0", i); end
            end
            for (int g = 0; g < gap[i]; g++) begin
                tick();
                n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL gap_idle bit%0d: got 1 want 0", i); end
            end
        end
        n_cmp++; if (frame_done !== 1'b1 || frame_errors !== 4'd2) begin
            n_fail++; $display("FAIL gap_frame: got %b/%0d want 1/2", frame_done, frame_errors); end
        n_cmp++; if (total_frames !== 32'd5 || total_bit_errors !== 32'd5 || total_frame_errors !== 32'd3) begin
            n_fail++; $display("FAIL gap_totals: got %0d/%0d/%0d want 5/5/3", total_frames, total_bit_errors, total_frame_errors); end
    endtask

    task automatic test_load_release();
        logic [7:0] a;
        a = 8'h5A;
        load_ref(a);
        for (int i = 0; i < 7; i++) send_bit(a[i]);
        set_ref(8'h3C);
        ref_valid = 1'b1;
        in_valid  = 1'b1;
        single_x  = a[7];
        tick();
        ref_valid = 1'b0;
        in_valid  = 1'b0;
        n_cmp++; if (frame_done !== 1'b1 || ref_ready !== 1'b1) begin
            n_fail++; $display("FAIL lr_done_ready: got %b/%b want 1/1", frame_done, ref_ready); end
        load_ref(8'hE1);
        n_cmp++; if (ref_ready !== 1'b0) begin n_fail++; $display("FAIL lr_occ2: got %b want 0", ref_ready); end
        send_frame(8'h3C);
        n_cmp++; if (frame_done !== 1'b1 || frame_errors !== 4'd0) begin
            n_fail++; $display("FAIL lr_second: got %b/%0d want 1/0", frame_done, frame_errors); end
        send_frame(8'hE1);
        n_cmp++; if (total_frames !== 32'd8 || total_bit_errors !== 32'd5 || total_frame_errors !== 32'd3) begin
            n_fail++; $display("FAIL lr_totals: got %0d/%0d/%0d want 8/5/3", total_frames, total_bit_errors, total_frame_errors); end
    endtask

    task automatic test_saturation();
        force dut.r_total_bit_errors = 32'hFFFF_FFFE;
        tick();
        release dut.r_total_bit_errors;
        tick();
        n_cmp++; if (total_bit_errors !== 32'hFFFF_FFFE) begin
            n_fail++; $display("FAIL sat_preset: got %h want fffffffe", total_bit_errors); end
        load_ref(8'hC7);
        send_frame(8'hC7 ^ 8'h07);
        n_cmp++; if (frame_errors !== 4'd3 || total_bit_errors !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL sat_clamp: got %0d/%h want 3/ffffffff", frame_errors, total_bit_errors); end
        load_ref(8'hC7);
        send_frame(8'hC7 ^ 8'h80);
        n_cmp++; if (total_bit_errors !== 32'hFFFF_FFFF || total_frames !== 32'd10 || total_frame_errors !== 32'd5) begin
            n_fail++; $display("FAIL sat_hold: got %h/%0d/%0d want ffffffff/10/5", total_bit_errors, total_frames, total_frame_errors); end
    endtask

    task automatic test_clear_reset();
        logic [7:0] f;
        f = 8'hC7;
        load_ref(f);
        for (int i = 0; i < 4; i++) send_bit(f[i]);
        clear = 1'b1; in_valid = 1'b1; single_x = 1'b1; ref_valid = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0; ref_valid = 1'b0;
        n_cmp++; if (frame_done !== 1'b0 || ref_ready !== 1'b1) begin
            n_fail++; $display("FAIL clr_done_ready: got %b/%b want 0/1", frame_done, ref_ready); end
        n_cmp++; if ({total_frames, total_bit_errors, total_frame_errors} !== 96'd0) begin
            n_fail++; $display("FAIL clr_totals: got %0d/%0d/%0d want 0/0/0", total_frames, total_bit_errors, total_frame_errors); end
        n_cmp++; if ({ref_overrun, no_ref_err, frame_error, frame_errors} !== 7'd0) begin
            n_fail++; $display("FAIL clr_flags: got %b/%b/%b/%0d want 0/0/0/0", ref_overrun, no_ref_err, frame_error, frame_errors); end
        load_ref(f);
        for (int i = 0; i < 8; i++) begin
            send_bit(f[i] ^ (i == 4));
            if (i < 7) begin
                n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL clr_early bit%0d: got 1 want 0", i); end
            end
        end
        n_cmp++; if (frame_done !== 1'b1 || frame_errors !== 4'd1 || total_frames !== 32'd1) begin
            n_fail++; $display("FAIL clr_next: got %b/%0d/%0d want 1/1/1", frame_done, frame_errors, total_frames); end
        load_ref(f);
        for (int i = 0; i < 4; i++) send_bit(f[i]);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (ref_ready !== 1'b1 || total_frames !== 32'd0 || frame_errors !== 4'd0) begin
            n_fail++; $display("FAIL rst_async: got %b/%0d/%0d want 1/0/0", ref_ready, total_frames, frame_errors); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got 1 want 0"); end
        end
        reset_n = 1'b1;
        tick();
        load_ref(f);
        for (int i = 0; i < 8; i++) begin
            send_bit(f[i]);
            if (i < 7) begin
                n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_early bit%0d: got 1 want 0", i); end
            end
        end
        n_cmp++; if (frame_done !== 1'b1 || frame_errors !== 4'd0 || total_frames !== 32'd1 || total_frame_errors !== 32'd0) begin
            n_fail++; $display("FAIL rst_next: got %b/%0d/%0d/%0d want 1/0/1/0", frame_done, frame_errors, total_frames, total_frame_errors); end
    endtask

    initial begin
        test_reset();
        test_error_free();
        test_errors();
        test_back_to_back();
        test_gaps_no_ref();
        test_load_release();
        test_saturation();
        test_clear_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
